// File: rtl/soma_arbiter.sv
// soma_arbiter
//   Round-robin arbiter and sequencer that shares one registered WIDTH-bit
//   adder among N_REQ client requesters. A request is granted in IDLE. Its
//   operands are latched and added in ADD. The result is held in RESP until
//   the granted requester takes it.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   req_valid   [N_REQ]        per-requester operand valid
//   req_ready   [N_REQ]        per-requester operand accept (one-hot or zero)
//   req_a/req_b [N_REQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid  [N_REQ]        per-requester result valid (one-hot or zero)
//   resp_ready  [N_REQ]        per-requester result taken
//   resp_sum    [WIDTH]        (a+b) mod 2^WIDTH, shared bus
//   resp_carry                 carry out of the add
//   busy                       high whenever the sequencer is not idle
//   op_count    [32]           completed-operation counter
//
// Build option
//   SOMA_ARB_STATS_EN  when defined, op_count counts completed responses.
//                      When undefined, op_count is constant 0.

module soma_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_carry,
  output logic                   busy,
  output logic [31:0]            op_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_gnt;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_carry;
  logic [N_REQ-1:0]        r_resp_valid;

  logic [N_REQ-1:0][WIDTH-1:0] w_a_arr;
  logic [N_REQ-1:0][WIDTH-1:0] w_b_arr;
  logic [2*N_REQ-1:0]      w_rot;
  logic [IDX_W-1:0]        w_off;
  logic [IDX_W:0]          w_wrap;
  logic [IDX_W-1:0]        w_gnt;
  logic                    w_gnt_any;
  logic [IDX_W-1:0]        w_gnt_next;
  logic                    w_accept;
  logic                    w_done;

  assign w_a_arr = req_a;
  assign w_b_arr = req_b;

  // Rotate the valid vector so that bit 0 is the requester at rr_ptr. The
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

  always_comb begin
    w_off     = '0;
    w_gnt_any = 1'b0;
    // Descending scan so that the lowest offset is assigned last and wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off     = IDX_W'(k);
        w_gnt_any = 1'b1;
      end
    end
    w_wrap = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_wrap >= (IDX_W+1)'(N_REQ)) begin
      w_wrap = w_wrap - (IDX_W+1)'(N_REQ);
    end
    w_gnt = w_wrap[IDX_W-1:0];
  end

  // Ready is presented combinationally in IDLE only. A raised ready implies
  // the matching valid, so the grant is also the accept.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_gnt_any) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_gnt_any;
  assign w_done     = (r_state == S_RESP) && resp_ready[r_gnt];
  assign w_gnt_next = (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_a_arr[w_gnt];
            r_b     <= w_b_arr[w_gnt];
            r_gnt   <= w_gnt;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          {r_carry, r_sum} <= {1'b0, r_a} + {1'b0, r_b};
          r_resp_valid     <= N_REQ'(1) << r_gnt;
          r_state          <= S_RESP;
        end
        S_RESP: begin
          // Only the granted requester's resp_ready can complete the op.
          if (w_done) begin
            r_resp_valid <= '0;
            r_rr_ptr     <= w_gnt_next;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= '0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_sum;
  assign resp_carry = r_carry;
  assign busy       = (r_state != S_IDLE);

`ifdef SOMA_ARB_STATS_EN
  logic [31:0] r_op_count;

  // Counts completion edges only. An op aborted by reset never reaches RESP
  // completion, and reset clears the count anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_done) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign op_count = r_op_count;
`else
  assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_soma_arbiter.sv
module tb_soma_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready;
  logic [W-1:0]     resp_sum;
  logic             resp_carry;
  logic             busy;
  logic [31:0]      op_count;

  soma_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_carry(resp_carry),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [W-1:0] sum;
    logic       carry;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           m_rr  = 0;
  int           m_ops = 0;
  logic [W-1:0] op_a[N];
  logic [W-1:0] op_b[N];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  function automatic int model_gnt(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // Raises the masked valids and retires each one as the DUT grants it,
  // pushing the expected response. Returns at accept-edge + 1 of the last grant.
  task automatic grant_phase(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    logic [N-1:0] oh;
    logic [W:0]   s;
    int           eg;
    exp_t         e;
    pend = mask;
    load_ops();
    @(posedge clk); #1;
    req_valid = pend;
    for (int c = 0; c < 200 && pend != 0; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        eg = model_gnt(pend);
        oh = '0;
        oh[eg] = 1'b1;
        chk("grant", req_ready, oh);
        s = {1'b0, op_a[eg]} + {1'b0, op_b[eg]};
        e.idx = eg; e.sum = s[W-1:0]; e.carry = s[W];
        sb.push_back(e);
        pend[eg] = 1'b0;
      end
      @(posedge clk); #1;
      req_valid = pend;
    end
    if (pend != 0) chk("grant_timeout", pend, 0);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1;
    end
    if (!ok) chk("drain_timeout", sb.size(), 0);
  endtask

  // Response monitor: every completed response must match the scoreboard head.
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] oh;
    if (!rst) begin
      if ($countones(req_ready) > 1) chk("ready_onehot", req_ready, 0);
      if (resp_valid != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", resp_valid, 0);
        end else if ((resp_valid & resp_ready) != 0) begin
          e = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("resp_idx", resp_valid, oh);
          chk("resp_sum", resp_sum, e.sum);
          chk("resp_carry", resp_carry, e.carry);
          m_rr = (e.idx + 1) % N;
          m_ops++;
        end
      end
    end
  end

  initial begin
    bit seen;
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_carry", resp_carry, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All four at once from rr_ptr=0: grants 0,1,2,3.
    op_a[0] = 13; op_b[0] = 50;
    op_a[1] = 4;  op_b[1] = 7;
    op_a[2] = 49; op_b[2] = 74;
    op_a[3] = 1;  op_b[3] = 1;
    grant_phase(4'b1111);
    drain();

    // Single request with latency: ADD, then RESP, then idle.
    op_a[0] = 4; op_b[0] = 6;
    grant_phase(4'b0001);
    @(negedge clk);
    chk("lat_add_busy", busy, 1);
    chk("lat_add_rv", resp_valid, 0);
    @(negedge clk);
    chk("lat_resp_rv", resp_valid, 4'b0001);
    chk("lat_resp_sum", resp_sum, 10);
    chk("lat_resp_carry", resp_carry, 0);
    @(posedge clk); #1;
    chk("lat_idle_busy", busy, 0);
    drain();

    // Overflow cases, both pending together.
    op_a[3] = '1;                     op_b[3] = 64'd1;
    op_a[2] = 64'h8000_0000_0000_0000; op_b[2] = 64'h8000_0000_0000_0000;
    grant_phase(4'b1100);
    drain();

    // Back-pressure on requester 1 while requester 0 waits.
    resp_ready = 4'b1101;
    op_a[1] = 100; op_b[1] = 200;
    op_a[0] = 9;   op_b[0] = 11;
    grant_phase(4'b0010);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid[1]) seen = 1;
    end
    if (!seen) chk("bp_resp_timeout", resp_valid, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_rv", resp_valid, 4'b0010);
      chk("bp_hold_sum", resp_sum, 300);
      chk("bp_no_grant", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = '1;
    req_valid  = '0;
    @(posedge clk); #1;
    chk("bp_idle", busy, 0);
    grant_phase(4'b0001);
    drain();

    // Asynchronous reset during ADD discards the op.
    op_a[1] = 7; op_b[1] = 8;
    load_ops();
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rmid_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rmid_in_add", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_rv", resp_valid, 0);
    chk("rmid_sum", resp_sum, 0);
    chk("rmid_carry", resp_carry, 0);
    chk("rmid_op_count", op_count, 0);
    m_rr  = 0;
    m_ops = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    op_a[2] = 5; op_b[2] = 5;
    grant_phase(4'b0100);
    drain();

    // Everyone again with rr_ptr=3: grants 3,0,1,2.
    op_a[0] = 64'h0123_4567_89AB_CDEF; op_b[0] = 64'hFEDC_BA98_7654_3211;
    op_a[1] = 64'd1000;               op_b[1] = 64'd2345;
    op_a[2] = 64'hFFFF_FFFF_0000_0000; op_b[2] = 64'h0000_0001_0000_0000;
    op_a[3] = 64'd77;                 op_b[3] = 64'd0;
    grant_phase(4'b1111);
    drain();

`ifdef SOMA_ARB_STATS_EN
    chk("op_count", op_count, m_ops);
`else
    chk("op_count_off", op_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
